data_bus_arbiter: RTL and testbench

Two-master arbiter and access sequencer for the single-port data memory / peripheral bus. It sits between the core's load-store path (master 0) and a second bus master (master 1, a DMA or debug port), and the address decoder + data memory (slave). It grants the bus round-robin, registers the winning request, drives exactly one slave access, captures the synchronous-read data one cycle later, and returns a one-cycle acknowledge to the winner.

---
 rtl/riscv_bus_pkg.sv | 25 ++
 rtl/rr_arbiter2.sv | 20 ++
 rtl/data_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_data_bus_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_bus_pkg.sv
// Shared data-bus types: arbiter state, master indices
// and the latched bus command.
package riscv_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = BUS_DATA_W / 8;

  localparam logic MASTER_CORE = 1'b0;
  localparam logic MASTER_AUX  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } bus_arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_BE_W-1:0]   be;
  } bus_cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on contention the master
// that did not own the bus last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    grant = 1'b0;
    valid = |req;
    unique case (1'b1)
      (req == 2'b11): grant = ~last_grant;
      (req == 2'b10): grant = 1'b1;
      default:        grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data-bus arbiter: round-robin grant, one
// latched slave access, one-cycle ack to the owner.
module data_bus_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  output logic                    m0_ack_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  output logic                    m1_ack_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    busy_o,
  output logic                    grant_o
);

  bus_arb_state_t        state;
  bus_cmd_t              cmd_q;
  bus_cmd_t              cmd_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  grant_q;
  logic                  last_grant_q;
  logic                  pick;
  logic                  pick_vld;

  rr_arbiter2 u_rr (
    .req        ({m1_req_i, m0_req_i}),
    .last_grant (last_grant_q),
    .grant      (pick),
    .valid      (pick_vld)
  );

  always_comb begin
    cmd_d = '0;
    if (pick == MASTER_AUX) begin
      cmd_d.we    = m1_we_i;
      cmd_d.addr  = m1_addr_i;
      cmd_d.wdata = m1_wdata_i;
      cmd_d.be    = m1_be_i;
    end else begin
      cmd_d.we    = m0_we_i;
      cmd_d.addr  = m0_addr_i;
      cmd_d.wdata = m0_wdata_i;
      cmd_d.be    = m0_be_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cmd_q        <= '0;
      rdata_q      <= '0;
      grant_q      <= MASTER_CORE;
      last_grant_q <= MASTER_AUX;
      s_req_o      <= 1'b0;
      busy_o       <= 1'b0;
      m0_ack_o     <= 1'b0;
      m1_ack_o     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            state   <= ACCESS;
            cmd_q   <= cmd_d;
            grant_q <= pick;
            s_req_o <= 1'b1;
            busy_o  <= 1'b1;
          end
        end
        ACCESS: begin
          state    <= RESP;
          s_req_o  <= 1'b0;
          m0_ack_o <= (grant_q == MASTER_CORE);
          m1_ack_o <= (grant_q == MASTER_AUX);
        end
        RESP: begin
          state        <= IDLE;
          busy_o       <= 1'b0;
          m0_ack_o     <= 1'b0;
          m1_ack_o     <= 1'b0;
          last_grant_q <= grant_q;
          if (!cmd_q.we) rdata_q <= s_rdata_i;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slave read data is only valid during RESP, so it is
  // forwarded then and held in rdata_q afterwards.
  logic [DATA_WIDTH-1:0] rdata_out;
  assign rdata_out = (state == RESP && !cmd_q.we) ?
                     s_rdata_i : rdata_q;

  assign m0_rdata_o = rdata_out;
  assign m1_rdata_o = rdata_out;
  assign s_we_o     = cmd_q.we;
  assign s_addr_o   = cmd_q.addr;
  assign s_wdata_o  = cmd_q.wdata;
  assign s_be_o     = cmd_q.be;
  assign grant_o    = grant_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: transaction-level
// model predicts grants, slave commands, ack timing and data.
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        ack_w [2];
  logic        m0_ack_o, m1_ack_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_we_o, busy_o, grant_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_be_o;

  assign ack_w[0] = m0_ack_o;
  assign ack_w[1] = m1_ack_o;

  data_bus_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .m0_req_i   (req[0]),
    .m0_we_i    (we[0]),
    .m0_addr_i  (addr[0]),
    .m0_wdata_i (wdata[0]),
    .m0_be_i    (be[0]),
    .m0_ack_o   (m0_ack_o),
    .m0_rdata_o (m0_rdata_o),
    .m1_req_i   (req[1]),
    .m1_we_i    (we[1]),
    .m1_addr_i  (addr[1]),
    .m1_wdata_i (wdata[1]),
    .m1_be_i    (be[1]),
    .m1_ack_o   (m1_ack_o),
    .m1_rdata_o (m1_rdata_o),
    .s_req_o    (s_req_o),
    .s_we_o     (s_we_o),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_be_o     (s_be_o),
    .s_rdata_i  (s_rdata_i),
    .busy_o     (busy_o),
    .grant_o    (grant_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gap;
    bit          drop;
  } txn_t;

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    int m;
    int c;
  } log_t;

  txn_t pend [2][$];
  txn_t cur  [2];
  bit   active  [2];
  bit   granted [2];
  exp_t sq[$];
  exp_t aq[$];
  log_t ack_log[$];
  int   grant_log[$];

  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  int          next_free = 0;
  int          model_last = 1;
  logic [31:0] last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(logic [31:0] a);
    return a ^ 32'h5AC3_96E1;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o,
                                        logic [31:0] w,
                                        logic [3:0]  b);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++)
      if (b[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_get(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] slv_get(logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
  endfunction

  // Synchronous-read slave; data is garbage except the
  // cycle after a read request.
  initial forever begin
    @(posedge clk);
    if (s_req_o) begin
      if (s_we_o)
        slave_mem[s_addr_o] = merge(slv_get(s_addr_o),
                                    s_wdata_o, s_be_o);
      else
        s_rdata_i <= slv_get(s_addr_o);
    end else begin
      s_rdata_i <= $urandom;
    end
  end

  // Bus is free again three cycles after a grant; the
  // non-last master wins a tie.
  task automatic model_step();
    int   w;
    exp_t e;
    if (cyc < next_free || !(req[0] || req[1])) return;
    if (req[0] && req[1]) w = 1 - model_last;
    else w = req[0] ? 0 : 1;
    e.m       = w;
    e.we      = we[w];
    e.addr    = addr[w];
    e.wdata   = wdata[w];
    e.be      = be[w];
    e.acc_cyc = cyc + 1;
    if (e.we) begin
      ref_mem[e.addr] = merge(ref_get(e.addr), e.wdata, e.be);
      e.rdata = last_rd;
    end else begin
      e.rdata = ref_get(e.addr);
      last_rd = e.rdata;
    end
    sq.push_back(e);
    grant_log.push_back(cyc);
    next_free  = cyc + 3;
    model_last = w;
    granted[w] = 1'b1;
  endtask

  task automatic drive(int m);
    txn_t t;
    if (active[m] && ack_w[m]) begin
      active[m] = 1'b0;
      req[m]    = 1'b0;
    end
    if (active[m] && cur[m].drop && granted[m]) begin
      req[m]   = 1'b0;
      addr[m]  = ~addr[m];
      wdata[m] = ~wdata[m];
      be[m]    = ~be[m];
    end
    if (!active[m] && pend[m].size() > 0) begin
      t = pend[m][0];
      if (t.gap > 0) begin
        t.gap--;
        pend[m][0] = t;
      end else begin
        void'(pend[m].pop_front());
        cur[m]     = t;
        active[m]  = 1'b1;
        granted[m] = 1'b0;
        req[m]     = 1'b1;
        we[m]      = t.we;
        addr[m]    = t.addr;
        wdata[m]   = t.wdata;
        be[m]      = t.be;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst) return;
    drive(0);
    drive(1);
    model_step();
  endtask

  task automatic run_until_idle(int limit);
    int n = 0;
    while ((pend[0].size() > 0 || pend[1].size() > 0 ||
            active[0] || active[1] ||
            sq.size() > 0 || aq.size() > 0) && n < limit) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(n < limit), 64'd1);
  endtask

  function automatic txn_t mk(logic w, logic [31:0] a,
                              logic [31:0] d, logic [3:0] b,
                              int g, bit dr);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d;
    t.be = b; t.gap = g; t.drop = dr;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk(1'($urandom_range(0, 1)),
              32'h100 + 32'($urandom_range(0, 7)) * 4,
              $urandom, 4'($urandom_range(1, 15)),
              $urandom_range(0, 3), 1'b0);
  endfunction

  initial forever begin
    exp_t e;
    int   am;
    @(negedge clk);
    if (!rst) begin
      if (m0_ack_o && m1_ack_o) chk("dual_ack", 64'd1, 64'd0);
      if (s_req_o) begin
        if (sq.size() == 0) begin
          chk("unexpected_access", {31'd0, s_addr_o}, 64'd0);
        end else begin
          e = sq.pop_front();
          chk("acc_cycle", 64'(cyc), 64'(e.acc_cyc));
          chk("acc_we", 64'(s_we_o), 64'(e.we));
          chk("acc_addr", 64'(s_addr_o), 64'(e.addr));
          chk("acc_be", 64'(s_be_o), 64'(e.be));
          chk("acc_grant", 64'(grant_o), 64'(e.m));
          chk("acc_busy", 64'(busy_o), 64'd1);
          if (e.we) chk("acc_wdata", 64'(s_wdata_o),
                        64'(e.wdata));
          aq.push_back(e);
        end
      end
      if (m0_ack_o || m1_ack_o) begin
        am = m1_ack_o ? 1 : 0;
        if (aq.size() == 0) begin
          chk("unexpected_ack", 64'(am), 64'd2);
        end else begin
          e = aq.pop_front();
          chk("ack_master", 64'(am), 64'(e.m));
          chk("ack_cycle", 64'(cyc), 64'(e.acc_cyc + 1));
          chk("ack_busy", 64'(busy_o), 64'd1);
          chk("m0_rdata", 64'(m0_rdata_o), 64'(e.rdata));
          chk("m1_rdata", 64'(m1_rdata_o), 64'(e.rdata));
          ack_log.push_back('{m: am, c: cyc});
        end
      end
    end
  end

  task automatic reset_all();
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0;
      wdata[m] = '0; be[m] = '0;
      active[m] = 1'b0; granted[m] = 1'b0;
      pend[m].delete();
    end
    sq.delete();
    aq.delete();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    next_free  = cyc;
    model_last = 1;
    last_rd    = '0;
  endtask

  initial begin
    int t0;
    reset_all();
    s_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_req", 64'(s_req_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_acks", 64'({m0_ack_o, m1_ack_o}), 64'd0);
    chk("rst_s_we", 64'(s_we_o), 64'd0);
    chk("rst_s_addr", 64'(s_addr_o), 64'd0);
    chk("rst_rdata", 64'(m0_rdata_o), 64'd0);
    release_rst();

    slave_mem[32'h10] = 32'hDEADBEEF;
    ref_mem[32'h10]   = 32'hDEADBEEF;
    pend[0].push_back(mk(1'b0, 32'h10, '0, 4'hF, 0, 1'b0));
    run_until_idle(50);

    pend[1].push_back(mk(1'b1, 32'h8000_0800, 32'hCAFEF00D,
                         4'hF, 0, 1'b0));
    run_until_idle(50);
    @(negedge clk);
    chk("rdata_hold_write", 64'(m1_rdata_o), 64'hDEADBEEF);

    ack_log.delete();
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      pend[0].push_back(mk(1'b0, 32'h10, '0, 4'hF, 0, 1'b0));
      pend[1].push_back(rnd_txn());
      pend[1][i].gap = 0;
    end
    run_until_idle(100);
    chk("rr_count", 64'(ack_log.size()), 64'd4);
    if (ack_log.size() == 4 && grant_log.size() > 0) begin
      t0 = grant_log[0];
      for (int i = 0; i < 4; i++) begin
        chk("rr_order", 64'(ack_log[i].m), 64'(i % 2));
        chk("rr_ack_offset", 64'(ack_log[i].c - t0),
            64'(2 + 3 * i));
      end
    end

    ack_log.delete();
    pend[0].push_back(mk(1'b0, 32'h20, '0, 4'h3, 0, 1'b1));
    run_until_idle(50);
    chk("drop_ack_count", 64'(ack_log.size()), 64'd1);

    pend[0].push_back(mk(1'b0, 32'h104, '0, 4'hF, 0, 1'b0));
    for (int n = 0; n < 20 && !granted[0]; n++) step();
    chk("pre_rst_grant", 64'(granted[0]), 64'd1);
    @(posedge clk);
    #1;
    reset_all();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_s_req", 64'(s_req_o), 64'd0);
    chk("midrst_acks", 64'({m0_ack_o, m1_ack_o}), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_rdata", 64'(m0_rdata_o), 64'd0);
    release_rst();
    ack_log.delete();
    pend[0].push_back(rnd_txn());
    pend[1].push_back(rnd_txn());
    pend[0][0].gap = 0;
    pend[1][0].gap = 0;
    run_until_idle(50);
    chk("post_rst_count", 64'(ack_log.size()), 64'd2);
    if (ack_log.size() > 0)
      chk("post_rst_first", 64'(ack_log[0].m), 64'd0);

    for (int i = 0; i < 150; i++) begin
      pend[0].push_back(rnd_txn());
      pend[1].push_back(rnd_txn());
    end
    run_until_idle(5000);
    chk("drain_sq", 64'(sq.size()), 64'd0);
    chk("drain_aq", 64'(aq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
